// File: rtl/leaf_user_port_adapter.sv
// rtl/leaf_user_port_adapter.sv - kernel-side endpoint of one leaf port pair with FWFT buffering
//
// leaf_user_port_adapter_fifo
//   wr_data/wr_valid/wr_ready : push side; wr_ready is a registered "space available" flag
//   rd_data/rd_valid/rd_ready : pop side; rd_data is the head, rd_valid a registered "not empty" flag
//   wr_fire/rd_fire           : a push / pop takes effect at the coming edge
//
// leaf_user_port_adapter
//   clk_user, reset                       : user clock, synchronous active-high reset
//   dout_leaf_interface2user, vld_interface2user, ack_user2interface : word stream from the leaf interface
//   in_dout, in_empty_n, in_read          : ap_fifo read port toward the kernel
//   out_din, out_write, out_full_n        : ap_fifo write port from the kernel
//   din_leaf_user2interface, vld_user2interface, ack_interface2user : word stream toward the leaf interface
//   in_words, out_words                   : free-running transfer counters, wrap modulo 2^32

module leaf_user_port_adapter_fifo #(
    parameter int W          = 32,
    parameter int DEPTH_BITS = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] wr_data,
    input  logic         wr_valid,
    output logic         wr_ready,
    output logic [W-1:0] rd_data,
    output logic         rd_valid,
    input  logic         rd_ready,
    output logic         wr_fire,
    output logic         rd_fire
);
    localparam int DEPTH = 1 << DEPTH_BITS;
    localparam logic [DEPTH_BITS:0] DEPTH_CNT = (DEPTH_BITS + 1)'(DEPTH);

    logic [W-1:0]          r_mem [DEPTH];
    logic [DEPTH_BITS-1:0] r_wr_ptr;
    logic [DEPTH_BITS-1:0] r_rd_ptr;
    logic [DEPTH_BITS:0]   r_count;
    logic                  r_wr_ready;
    logic                  r_rd_valid;
    logic [DEPTH_BITS:0]   w_next_count;
    logic                  w_push;
    logic                  w_pop;

    // Flags are registered, so a transfer only happens against the flag the
    // other side already sees; this keeps the handshake free of comb paths.
    assign w_push = wr_valid & r_wr_ready;
    assign w_pop  = rd_ready & r_rd_valid;

    always_comb begin
        w_next_count = r_count;
        case ({w_push, w_pop})
            2'b10:   w_next_count = r_count + 1'b1;
            2'b01:   w_next_count = r_count - 1'b1;
            default: w_next_count = r_count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_wr_ready <= 1'b0;
            r_rd_valid <= 1'b0;
            // Clearing storage makes the head read 0 during and right after reset.
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= wr_data;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count    <= w_next_count;
            r_wr_ready <= (w_next_count < DEPTH_CNT);
            r_rd_valid <= (w_next_count != '0);
        end
    end

    // First-word-fall-through: the head slot is read directly. While the
    // FIFO is non-empty the head slot cannot be overwritten, so an offered
    // word stays stable until it is popped.
    assign rd_data  = r_mem[r_rd_ptr];
    assign rd_valid = r_rd_valid;
    assign wr_ready = r_wr_ready;
    assign wr_fire  = w_push;
    assign rd_fire  = w_pop;
endmodule

module leaf_user_port_adapter #(
    parameter int PAYLOAD_BITS = 32,
    parameter int DEPTH_BITS   = 2
) (
    input  logic                    clk_user,
    input  logic                    reset,
    input  logic [PAYLOAD_BITS-1:0] dout_leaf_interface2user,
    input  logic                    vld_interface2user,
    output logic                    ack_user2interface,
    output logic [PAYLOAD_BITS-1:0] in_dout,
    output logic                    in_empty_n,
    input  logic                    in_read,
    input  logic [PAYLOAD_BITS-1:0] out_din,
    input  logic                    out_write,
    output logic                    out_full_n,
    output logic [PAYLOAD_BITS-1:0] din_leaf_user2interface,
    output logic                    vld_user2interface,
    input  logic                    ack_interface2user,
    output logic [31:0]             in_words,
    output logic [31:0]             out_words
);
    logic        w_in_push;
    logic        w_in_pop;
    logic        w_out_push;
    logic        w_out_pop;
    logic [31:0] r_in_words;
    logic [31:0] r_out_words;

    leaf_user_port_adapter_fifo #(
        .W          (PAYLOAD_BITS),
        .DEPTH_BITS (DEPTH_BITS)
    ) u_in_fifo (
        .clk      (clk_user),
        .reset    (reset),
        .wr_data  (dout_leaf_interface2user),
        .wr_valid (vld_interface2user),
        .wr_ready (ack_user2interface),
        .rd_data  (in_dout),
        .rd_valid (in_empty_n),
        .rd_ready (in_read),
        .wr_fire  (w_in_push),
        .rd_fire  (w_in_pop)
    );

    leaf_user_port_adapter_fifo #(
        .W          (PAYLOAD_BITS),
        .DEPTH_BITS (DEPTH_BITS)
    ) u_out_fifo (
        .clk      (clk_user),
        .reset    (reset),
        .wr_data  (out_din),
        .wr_valid (out_write),
        .wr_ready (out_full_n),
        .rd_data  (din_leaf_user2interface),
        .rd_valid (vld_user2interface),
        .rd_ready (ack_interface2user),
        .wr_fire  (w_out_push),
        .rd_fire  (w_out_pop)
    );

    // Counters track interface-side transfers only: words accepted from the
    // leaf interface and words it has taken from us.
    always_ff @(posedge clk_user) begin
        if (reset) begin
            r_in_words  <= '0;
            r_out_words <= '0;
        end else begin
            if (w_in_push) begin
                r_in_words <= r_in_words + 32'd1;
            end
            if (w_out_pop) begin
                r_out_words <= r_out_words + 32'd1;
            end
        end
    end

    assign in_words  = r_in_words;
    assign out_words = r_out_words;

    logic w_unused;
    assign w_unused = w_in_pop ^ w_out_push;
endmodule

// File: tb/tb_leaf_user_port_adapter.sv
// tb/tb_leaf_user_port_adapter.sv - self-checking bench for leaf_user_port_adapter

module tb_leaf_user_port_adapter;
    localparam int DEPTH = 4;

    logic        clk_user = 1'b0;
    logic        reset;
    logic [31:0] dout_leaf_interface2user;
    logic        vld_interface2user;
    logic        ack_user2interface;
    logic [31:0] in_dout;
    logic        in_empty_n;
    logic        in_read;
    logic [31:0] out_din;
    logic        out_write;
    logic        out_full_n;
    logic [31:0] din_leaf_user2interface;
    logic        vld_user2interface;
    logic        ack_interface2user;
    logic [31:0] in_words;
    logic [31:0] out_words;

    leaf_user_port_adapter dut (
        .clk_user                 (clk_user),
        .reset                    (reset),
        .dout_leaf_interface2user (dout_leaf_interface2user),
        .vld_interface2user       (vld_interface2user),
        .ack_user2interface       (ack_user2interface),
        .in_dout                  (in_dout),
        .in_empty_n               (in_empty_n),
        .in_read                  (in_read),
        .out_din                  (out_din),
        .out_write                (out_write),
        .out_full_n               (out_full_n),
        .din_leaf_user2interface  (din_leaf_user2interface),
        .vld_user2interface       (vld_user2interface),
        .ack_interface2user       (ack_interface2user),
        .in_words                 (in_words),
        .out_words                (out_words)
    );

    always #5 clk_user = ~clk_user;

    // Reference model: two bounded queues plus counters.
    logic [31:0] qin[$];
    logic [31:0] qout[$];
    logic [31:0] m_in_words;
    logic [31:0] m_out_words;
    bit          m_live;      // 0 only in the cycle(s) where reset was last sampled
    int          n_checks;
    int          n_fail;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("ack_user2interface", {31'b0, ack_user2interface}, {31'b0, m_live && qin.size() < DEPTH});
        chk("in_empty_n",         {31'b0, in_empty_n},         {31'b0, qin.size() != 0});
        chk("out_full_n",         {31'b0, out_full_n},         {31'b0, m_live && qout.size() < DEPTH});
        chk("vld_user2interface", {31'b0, vld_user2interface}, {31'b0, qout.size() != 0});
        chk("in_words",  in_words,  m_in_words);
        chk("out_words", out_words, m_out_words);
        if (qin.size() != 0)  chk("in_dout", in_dout, qin[0]);
        else if (!m_live)     chk("in_dout_reset", in_dout, 32'h0);
        if (qout.size() != 0) chk("din_leaf_user2interface", din_leaf_user2interface, qout[0]);
        else if (!m_live)     chk("din_leaf_reset", din_leaf_user2interface, 32'h0);
    endtask

    // Advance one clock: decide transfers from the model's visible state and
    // the current inputs, then compare every output just after the edge.
    task automatic cyc();
        bit          ip, ipop, op, opop, rst;
        logic [31:0] idata, odata;
        rst   = reset;
        ip    = m_live && vld_interface2user && qin.size() < DEPTH;
        ipop  = in_read && qin.size() != 0;
        op    = m_live && out_write && qout.size() < DEPTH;
        opop  = ack_interface2user && qout.size() != 0;
        idata = dout_leaf_interface2user;
        odata = out_din;
        @(posedge clk_user);
        #1;
        if (rst) begin
            qin.delete();
            qout.delete();
            m_in_words  = 0;
            m_out_words = 0;
            m_live      = 0;
        end else begin
            if (ipop) void'(qin.pop_front());
            if (ip) begin
                qin.push_back(idata);
                m_in_words++;
            end
            if (opop) begin
                void'(qout.pop_front());
                m_out_words++;
            end
            if (op) qout.push_back(odata);
            m_live = 1;
        end
        check_all();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        m_live   = 0;
        m_in_words  = 0;
        m_out_words = 0;
        reset = 1'b1;
        dout_leaf_interface2user = '0;
        vld_interface2user = 1'b0;
        in_read = 1'b0;
        out_din = '0;
        out_write = 1'b0;
        ack_interface2user = 1'b0;

        // Reset values, then ready in the first cycle after release.
        repeat (3) cyc();
        reset = 1'b0;
        cyc();
        chk("ready_ack_after_reset",   {31'b0, ack_user2interface}, 32'd1);
        chk("ready_fulln_after_reset", {31'b0, out_full_n},         32'd1);

        // Input fill to full, a held fifth word is refused, then drain in order.
        vld_interface2user = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            dout_leaf_interface2user = 32'h11 * i;
            cyc();
        end
        chk("in_full_ack_low", {31'b0, ack_user2interface}, 32'd0);
        dout_leaf_interface2user = 32'h55;
        repeat (2) cyc();
        vld_interface2user = 1'b0;
        in_read = 1'b1;
        repeat (4) cyc();
        in_read = 1'b0;
        cyc();
        chk("in_words_after_fill", in_words, 32'd4);

        // Output backpressure: four writes fill, the fifth is dropped.
        out_write = 1'b1;
        for (int i = 0; i < 5; i++) begin
            out_din = 32'hA0 + i;
            cyc();
        end
        out_write = 1'b0;
        repeat (2) cyc();
        chk("held_offer_head", din_leaf_user2interface, 32'hA0);
        ack_interface2user = 1'b1;
        repeat (4) cyc();
        ack_interface2user = 1'b0;
        cyc();
        chk("out_words_after_drain", out_words, 32'd4);

        // Streaming push and pop through pointer wrap.
        vld_interface2user = 1'b1;
        in_read = 1'b1;
        for (int i = 0; i < 20; i++) begin
            dout_leaf_interface2user = i;
            cyc();
        end
        vld_interface2user = 1'b0;
        cyc();
        in_read = 1'b0;

        // Full boundary: fill, then pop while vld stays high.
        vld_interface2user = 1'b1;
        for (int i = 0; i < 4; i++) begin
            dout_leaf_interface2user = 32'h80 + i;
            cyc();
        end
        dout_leaf_interface2user = 32'h90;
        in_read = 1'b1;
        cyc();
        chk("ack_rises_after_pop_from_full", {31'b0, ack_user2interface}, 32'd1);
        cyc();
        vld_interface2user = 1'b0;
        repeat (5) cyc();
        in_read = 1'b0;

        // Reset mid-operation with three words in each FIFO and a push pending.
        vld_interface2user = 1'b1;
        out_write = 1'b1;
        for (int i = 0; i < 3; i++) begin
            dout_leaf_interface2user = 32'hC0 + i;
            out_din = 32'hD0 + i;
            cyc();
        end
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        vld_interface2user = 1'b0;
        out_write = 1'b0;
        cyc();
        chk("in_words_restart", in_words, 32'd0);
        vld_interface2user = 1'b1;
        dout_leaf_interface2user = 32'h77;
        out_write = 1'b1;
        out_din = 32'h77;
        cyc();
        vld_interface2user = 1'b0;
        out_write = 1'b0;
        chk("first_after_reset_in",  in_dout, 32'h77);
        chk("first_after_reset_out", din_leaf_user2interface, 32'h77);
        in_read = 1'b1;
        ack_interface2user = 1'b1;
        cyc();
        in_read = 1'b0;
        ack_interface2user = 1'b0;
        cyc();

        // Counter wrap.
        force dut.r_in_words = 32'hFFFF_FFFF;
        #1;
        release dut.r_in_words;
        m_in_words = 32'hFFFF_FFFF;
        chk("in_words_forced", in_words, 32'hFFFF_FFFF);
        vld_interface2user = 1'b1;
        dout_leaf_interface2user = 32'h1234;
        cyc();
        vld_interface2user = 1'b0;
        chk("in_words_wrap", in_words, 32'h0);
        in_read = 1'b1;
        cyc();
        in_read = 1'b0;

        // Randomized traffic with occasional resets; the read/ack bias changes
        // per phase so occupancy sweeps from mostly-empty to mostly-full.
        for (int ph = 0; ph < 4; ph++) begin
            for (int n = 0; n < 150; n++) begin
                reset = ($urandom_range(0, 99) == 0);
                vld_interface2user       = $urandom_range(0, 1);
                dout_leaf_interface2user = $urandom;
                out_write                = $urandom_range(0, 1);
                out_din                  = $urandom;
                in_read            = ($urandom_range(0, 3) < (ph + 1));
                ack_interface2user = ($urandom_range(0, 3) < (4 - ph));
                cyc();
            end
        end
        reset = 1'b0;
        vld_interface2user = 1'b0;
        out_write = 1'b0;
        in_read = 1'b1;
        ack_interface2user = 1'b1;
        repeat (6) cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
